// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and limits for the memory responder
package mem_pkg;
    localparam int ADDR_W         = 2;
    localparam int DATA_W         = 8;
    localparam int MAX_RD_LATENCY = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  valid;
        data_t data;
        logic  err;
    } rd_pipe_t;
endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - fixed-depth read response shift register, one entry per cycle
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rd_pipe_t in_i,
    output rd_pipe_t out_o
);
    rd_pipe_t stage_q [DEPTH];

    // Whole entries are cleared so rdata/rd_err read back 0 outside a valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory responder: storage, written flags, read pipeline, access counters
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);
    localparam int DEPTH = 2 ** ADDR_W;

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("mem_responder: RD_LATENCY must be 1..%0d", MAX_RD_LATENCY);
    end
    if (DATA_W != mem_pkg::DATA_W) begin : g_bad_width
        $error("mem_responder: DATA_W must match mem_pkg::DATA_W");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    rd_pipe_t          rd_in, rd_out;

    // Captured from the pre-edge array, so a same-address write lands after the read.
    always_comb begin
        rd_in = '0;
        if (rd_en) begin
            rd_in.valid = 1'b1;
            rd_in.data  = mem_q[addr];
            rd_in.err   = ~written_q[addr];
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (wr_en && wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
        if (rd_en && rd_count_q != '1) rd_count_d = rd_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            written_q  <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[addr]     <= wdata;
                written_q[addr] <= 1'b1;
            end
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) assert (!$isunknown({wr_en, rd_en})) else $error("mem_responder: unknown wr_en/rd_en");
    end

    mem_rd_pipe #(.DEPTH(RD_LATENCY)) u_rd_pipe (
        .clk   (clk),
        .rst_n (reset),
        .in_i  (rd_in),
        .out_o (rd_out)
    );

    assign rdata    = rd_out.data;
    assign rd_valid = rd_out.valid;
    assign rd_err   = rd_out.err;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - three responder configurations checked against a queue-based model
module tb_mem_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] addr = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = '0;

    logic [7:0]  a_rdata, b_rdata, c_rdata;
    logic        a_rv, b_rv, c_rv, a_re, b_re, c_re;
    logic [15:0] a_wc, a_rc, b_wc, b_rc;
    logic [3:0]  c_wc, c_rc;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.RD_LATENCY(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
        .rdata(a_rdata), .rd_valid(a_rv), .rd_err(a_re), .wr_count(a_wc), .rd_count(a_rc));
    mem_responder #(.RD_LATENCY(3), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
        .rdata(b_rdata), .rd_valid(b_rv), .rd_err(b_re), .wr_count(b_wc), .rd_count(b_rc));
    mem_responder #(.RD_LATENCY(4), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
        .rdata(c_rdata), .rd_valid(c_rv), .rd_err(c_re), .wr_count(c_wc), .rd_count(c_rc));

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       e;
    } exp_t;

    localparam int LAT[3] = '{1, 3, 4};
    localparam int CW[3]  = '{16, 16, 4};
    string nm[3] = '{"lat1", "lat3", "lat4c4"};

    logic [7:0] m_mem [4];
    bit         m_wr  [4];
    int         m_wc, m_rc, m_edge;
    exp_t       q0[$], q1[$], q2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    // Reference: a read at edge e is due after edge e+LAT-1, read-before-write at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin m_mem[i] = 8'h00; m_wr[i] = 1'b0; end
            m_wc = 0; m_rc = 0;
            q0.delete(); q1.delete(); q2.delete();
        end else begin
            exp_t r;
            m_edge++;
            if (rd_en) begin
                r.d = m_mem[addr];
                r.e = !m_wr[addr];
                r.due = m_edge + LAT[0] - 1; q0.push_back(r);
                r.due = m_edge + LAT[1] - 1; q1.push_back(r);
                r.due = m_edge + LAT[2] - 1; q2.push_back(r);
                m_rc++;
            end
            if (wr_en) begin
                m_mem[addr] = wdata;
                m_wr[addr] = 1'b1;
                m_wc++;
            end
        end
    end

    task automatic check_inst(input int k, input logic v, input logic [7:0] d, input logic er,
                              input logic [15:0] wc, input logic [15:0] rc);
        exp_t f;
        logic ev;
        ev = 1'b0;
        f = '{due: 0, d: 8'h00, e: 1'b0};
        case (k)
            0: if (q0.size() > 0 && q0[0].due == m_edge) begin ev = 1'b1; f = q0.pop_front(); end
            1: if (q1.size() > 0 && q1[0].due == m_edge) begin ev = 1'b1; f = q1.pop_front(); end
            default: if (q2.size() > 0 && q2[0].due == m_edge) begin ev = 1'b1; f = q2.pop_front(); end
        endcase
        chk({nm[k], ".rd_valid"}, 32'(v), 32'(ev));
        chk({nm[k], ".rdata"}, 32'(d), ev ? 32'(f.d) : 32'h0);
        chk({nm[k], ".rd_err"}, 32'(er), ev ? 32'(f.e) : 32'h0);
        chk({nm[k], ".wr_count"}, 32'(wc), sat(m_wc, CW[k]));
        chk({nm[k], ".rd_count"}, 32'(rc), sat(m_rc, CW[k]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_inst(0, a_rv, a_rdata, a_re, a_wc, a_rc);
            check_inst(1, b_rv, b_rdata, b_re, b_wc, b_rc);
            check_inst(2, c_rv, c_rdata, c_re, 16'(c_wc), 16'(c_rc));
        end
    end

    task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
        wr_en = w; rd_en = r; addr = a; wdata = d;
        @(posedge clk); #2;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        m_edge = 0;
        idle(2);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset.rd_valid", 32'(a_rv), 32'h0);
        chk("reset.rdata", 32'(a_rdata), 32'h0);
        chk("reset.wr_count", 32'(c_wc), 32'h0);
        reset = 1'b1;

        drive(1'b0, 1'b1, 2'd2, 8'h00);
        @(negedge clk);
        chk("unwritten.rd_valid", 32'(a_rv), 32'h1);
        chk("unwritten.rdata", 32'(a_rdata), 32'h00);
        chk("unwritten.rd_err", 32'(a_re), 32'h1);
        chk("unwritten.rd_count", 32'(a_rc), 32'h1);

        drive(1'b1, 1'b0, 2'd1, 8'hA5);
        drive(1'b0, 1'b1, 2'd1, 8'h00);
        @(negedge clk);
        chk("wr_then_rd.rdata", 32'(a_rdata), 32'hA5);
        chk("wr_then_rd.rd_err", 32'(a_re), 32'h0);
        chk("wr_then_rd.wr_count", 32'(a_wc), 32'h1);

        drive(1'b1, 1'b0, 2'd3, 8'h3C);
        drive(1'b1, 1'b1, 2'd3, 8'h7E);
        @(negedge clk);
        chk("collision.rdata", 32'(a_rdata), 32'h3C);
        chk("collision.rd_err", 32'(a_re), 32'h0);
        drive(1'b0, 1'b1, 2'd3, 8'h00);
        @(negedge clk);
        chk("after_collision.rdata", 32'(a_rdata), 32'h7E);

        idle(5);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 8'h00);
            @(negedge clk);
            chk("burst.rd_valid", 32'(b_rv), (i >= 2) ? 32'h1 : 32'h0);
            if (i >= 2) chk("burst.rdata", 32'(b_rdata), 32'(8'h10 + i - 2));
        end
        for (int j = 2; j < 4; j++) begin
            idle(1);
            @(negedge clk);
            chk("burst_tail.rd_valid", 32'(b_rv), 32'h1);
            chk("burst_tail.rdata", 32'(b_rdata), 32'(8'h10 + j));
        end
        idle(1);
        @(negedge clk);
        chk("burst_end.rd_valid", 32'(b_rv), 32'h0);

        idle(5);
        drive(1'b0, 1'b1, 2'd0, 8'h00);
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset.rd_valid", 32'(b_rv), 32'h0);
        chk("midreset.rdata", 32'(b_rdata), 32'h0);
        chk("midreset.rd_count", 32'(b_rc), 32'h0);
        idle(2);
        reset = 1'b1;
        idle(4);
        drive(1'b0, 1'b1, 2'd0, 8'h00);
        idle(2);
        @(negedge clk);
        chk("post_reset.rd_valid", 32'(b_rv), 32'h1);
        chk("post_reset.rdata", 32'(b_rdata), 32'h00);
        chk("post_reset.rd_err", 32'(b_re), 32'h1);

        idle(4);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
        @(negedge clk);
        chk("sat.wr_count", 32'(c_wc), 32'd15);
        chk("sat.rd_count", 32'(c_rc), 32'd0);
        chk("sat.wide_wr_count", 32'(a_wc), 32'd17);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b0;
                idle(1);
                reset = 1'b1;
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 8'($urandom));
            end
        end
        idle(8);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
